// File: rtl/pr_irq_ctrl.sv
// pr_irq_ctrl: six-line programmable interrupt controller feeding the CPU HWInt input.
// Define PR_IRQ_NESTING_EN to let a higher-priority line preempt one already in service.
module pr_irq_ctrl #(
    parameter int          NUM_IRQ   = 6,
    parameter logic [31:0] BASE_ADDR = 32'h7F20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [29:0]        Addr,
    input  logic               WE,
    input  logic [31:0]        Din,
    output logic [31:0]        Dout,
    output logic [NUM_IRQ-1:0] HWInt
);

    localparam logic [1:0] REG_MASK = 2'd0;
    localparam logic [1:0] REG_MODE = 2'd1;
    localparam logic [1:0] REG_PEND = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;
    localparam logic [NUM_IRQ-1:0] ONE = NUM_IRQ'(1);

    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] mode;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] isr;
    logic [NUM_IRQ-1:0] irq_q;

    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] w1c_clr;
    logic [NUM_IRQ-1:0] ack_sel;
    logic [NUM_IRQ-1:0] ack_hit;
    logic [NUM_IRQ-1:0] pending_n;
    logic [NUM_IRQ-1:0] isr_n;
    logic [NUM_IRQ-1:0] allowed;
    logic [NUM_IRQ-1:0] eligible;

    logic [1:0] sel;
    logic       wr_mask;
    logic       wr_mode;
    logic       wr_pend;
    logic       wr_ack;
    logic       wr_eoi;
    logic [2:0] vec;
    logic       valid;
    logic       unused_bits;

    // Addr is prAddr[31:2], so byte-address bits [3:2] sit at Addr[1:0]
    assign sel     = Addr[1:0];
    assign wr_mask = WE && (sel == REG_MASK);
    assign wr_mode = WE && (sel == REG_MODE);
    assign wr_pend = WE && (sel == REG_PEND);
    assign wr_ack  = WE && (sel == REG_CTRL) && !Din[3];
    assign wr_eoi  = WE && (sel == REG_CTRL) && Din[3];

    assign unused_bits = ^{Addr[29:2], Din[31:NUM_IRQ], BASE_ADDR};

    // Indices 6 and 7 shift out of the vector, so those ACKs select nothing
    assign ack_sel = ONE << Din[2:0];

    always_comb begin
        rise      = irq_in & ~irq_q;
        w1c_clr   = wr_pend ? (Din[NUM_IRQ-1:0] & mode) : '0;
        ack_hit   = wr_ack ? (ack_sel & pending & mask) : '0;
        pending_n = (mode & ((pending & ~(w1c_clr | ack_hit)) | rise))
                  | (~mode & irq_in);
        isr_n     = wr_eoi ? (isr & (isr - ONE)) : (isr | ack_hit);
    end

`ifdef PR_IRQ_NESTING_EN
    // Only lines strictly above the highest-priority line in service may interrupt
    assign allowed = ~isr & (isr - ONE);
`else
    assign allowed = (isr == '0) ? '1 : '0;
`endif

    assign eligible = pending & mask & allowed;
    assign valid    = |eligible;

    always_comb begin
        vec = 3'd7;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                vec = 3'(i);
            end
        end
    end

    always_comb begin
        Dout = '0;
        unique case (sel)
            REG_MASK: Dout = 32'(mask);
            REG_MODE: Dout = 32'(mode);
            REG_PEND: Dout = 32'(pending);
            REG_CTRL: Dout = 32'({isr, 2'b00, valid, vec});
            default:  Dout = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask    <= '0;
            mode    <= '0;
            pending <= '0;
            isr     <= '0;
            irq_q   <= '0;
            HWInt   <= '0;
        end else begin
            irq_q   <= irq_in;
            pending <= pending_n;
            isr     <= isr_n;
            HWInt   <= valid ? (ONE << vec) : '0;
            if (wr_mask) begin
                mask <= Din[NUM_IRQ-1:0];
            end
            if (wr_mode) begin
                mode <= Din[NUM_IRQ-1:0];
            end
        end
    end

endmodule

// File: tb/tb_pr_irq_ctrl.sv
// tb_pr_irq_ctrl: directed plus random checks of pr_irq_ctrl against a line-by-line model.
// The model follows PR_IRQ_NESTING_EN the same way the design build does.
module tb_pr_irq_ctrl;

    localparam logic [29:0] BASE_WORD = 30'(32'h7F20 >> 2);
    localparam logic [1:0]  REG_MASK  = 2'd0;
    localparam logic [1:0]  REG_MODE  = 2'd1;
    localparam logic [1:0]  REG_PEND  = 2'd2;
    localparam logic [1:0]  REG_CTRL  = 2'd3;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  irq_in;
    logic [29:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic [5:0]  HWInt;

    int compared   = 0;
    int mismatched = 0;

    bit m_mask[6];
    bit m_mode[6];
    bit m_pend[6];
    bit m_isr[6];
    bit m_prev[6];
    logic [5:0] m_hw;

    logic [31:0] rd[4];
    logic [5:0]  hw_seen;

    pr_irq_ctrl dut (
        .clk    (clk),
        .reset  (reset),
        .irq_in (irq_in),
        .Addr   (Addr),
        .WE     (WE),
        .Din    (Din),
        .Dout   (Dout),
        .HWInt  (HWInt)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] pack6(input bit a[6]);
        logic [5:0] p;
        for (int i = 0; i < 6; i++) p[i] = a[i];
        return p;
    endfunction

    // Highest-priority requesting line the CPU may currently see, 7 when none
    function automatic int modelVec();
        int top;
        bool_check: begin end
        top = 6;
        for (int i = 5; i >= 0; i--) if (m_isr[i]) top = i;
`ifndef PR_IRQ_NESTING_EN
        if (top != 6) return 7;
`endif
        for (int i = 0; i < top; i++) if (m_pend[i] && m_mask[i]) return i;
        return 7;
    endfunction

    function automatic logic [31:0] modelRead(input int s);
        int v;
        v = modelVec();
        case (s)
            0:       return 32'(pack6(m_mask));
            1:       return 32'(pack6(m_mode));
            2:       return 32'(pack6(m_pend));
            default: return {20'b0, pack6(m_isr), 2'b00, (v != 7), 3'(v)};
        endcase
    endfunction

    task automatic modelEdge(input logic [5:0] irq, input logic we, input logic [1:0] s,
                             input logic [31:0] din, input logic rst);
        int  v;
        int  ack_line;
        int  eoi_line;
        bit  np[6];
        bit  ni[6];
        if (rst) begin
            for (int i = 0; i < 6; i++) begin
                m_mask[i] = 0; m_mode[i] = 0; m_pend[i] = 0; m_isr[i] = 0; m_prev[i] = 0;
            end
            m_hw = 6'd0;
            return;
        end
        v = modelVec();
        m_hw = (v == 7) ? 6'd0 : 6'(1 << v);
        ack_line = -1;
        eoi_line = -1;
        if (we && s == REG_CTRL && !din[3] && din[2:0] < 3'd6
            && m_pend[din[2:0]] && m_mask[din[2:0]]) ack_line = int'(din[2:0]);
        if (we && s == REG_CTRL && din[3])
            for (int i = 5; i >= 0; i--) if (m_isr[i]) eoi_line = i;
        for (int i = 0; i < 6; i++) begin
            ni[i] = m_isr[i];
            if (i == ack_line) ni[i] = 1;
            if (i == eoi_line) ni[i] = 0;
            if (m_mode[i]) begin
                np[i] = m_pend[i];
                if ((we && s == REG_PEND && din[i]) || i == ack_line) np[i] = 0;
                if (irq[i] && !m_prev[i]) np[i] = 1;
            end else begin
                np[i] = irq[i];
            end
        end
        for (int i = 0; i < 6; i++) begin
            m_pend[i] = np[i];
            m_isr[i]  = ni[i];
            m_prev[i] = irq[i];
            if (we && s == REG_MASK) m_mask[i] = din[i];
            if (we && s == REG_MODE) m_mode[i] = din[i];
        end
    endtask

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compares HWInt and all four register reads, keeping them for directed checks
    task automatic checkOutput(input string tag);
        WE = 1'b0;
        hw_seen = HWInt;
        checkValue({tag, "/HWInt"}, 32'(HWInt), 32'(m_hw));
        for (int s = 0; s < 4; s++) begin
            Addr = BASE_WORD | 30'(s);
            #1;
            rd[s] = Dout;
            checkValue($sformatf("%s/reg%0d", tag, s), Dout, modelRead(s));
        end
    endtask

    task automatic applyStimulus(input string tag, input logic [5:0] irq, input logic we,
                                 input logic [1:0] s, input logic [31:0] din, input logic rst);
        irq_in = irq;
        WE     = we;
        Addr   = BASE_WORD | 30'(s);
        Din    = din;
        reset  = rst;
        @(posedge clk);
        modelEdge(irq, we, s, din, rst);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        logic [5:0]  r_irq;
        logic        r_we;
        logic [1:0]  r_sel;
        logic [31:0] r_din;
        logic        r_rst;

        reset = 1'b1; irq_in = '0; WE = 1'b0; Addr = BASE_WORD; Din = '0;

        applyStimulus("reset", 6'h00, 1'b0, REG_MASK, 32'h0, 1'b1);
        checkValue("rst_mask", rd[0], 32'h0);
        checkValue("rst_mode", rd[1], 32'h0);
        checkValue("rst_pend", rd[2], 32'h0);
        checkValue("rst_ctrl", rd[3], 32'h7);
        checkValue("rst_hw", 32'(hw_seen), 32'h0);
        applyStimulus("idle", 6'h00, 1'b0, REG_MASK, 32'h0, 1'b0);
        checkValue("idle_hw", 32'(hw_seen), 32'h0);

        // Single edge request, ACK, EOI
        applyStimulus("t2_mask", 6'h00, 1'b1, REG_MASK, 32'h3F, 1'b0);
        applyStimulus("t2_mode", 6'h00, 1'b1, REG_MODE, 32'h01, 1'b0);
        applyStimulus("t2_pulse", 6'h01, 1'b0, REG_MASK, 32'h0, 1'b0);
        checkValue("t2_pend", rd[2], 32'h1);
        checkValue("t2_hw_early", 32'(hw_seen), 32'h0);
        applyStimulus("t2_wait", 6'h00, 1'b0, REG_MASK, 32'h0, 1'b0);
        checkValue("t2_hw", 32'(hw_seen), 32'h01);
        applyStimulus("t2_ack", 6'h00, 1'b1, REG_CTRL, 32'h0, 1'b0);
        checkValue("t2_ack_pend", rd[2], 32'h0);
        checkValue("t2_ack_isr", 32'(rd[3][11:6]), 32'h01);
        applyStimulus("t2_after", 6'h00, 1'b0, REG_MASK, 32'h0, 1'b0);
        checkValue("t2_hw_off", 32'(hw_seen), 32'h0);
        applyStimulus("t2_eoi", 6'h00, 1'b1, REG_CTRL, 32'h8, 1'b0);
        checkValue("t2_eoi_isr", 32'(rd[3][11:6]), 32'h0);

        // Level lines and fixed priority
        applyStimulus("t3_mode", 6'h00, 1'b1, REG_MODE, 32'h0, 1'b0);
        applyStimulus("t3_hold", 6'b000110, 1'b0, REG_MASK, 32'h0, 1'b0);
        applyStimulus("t3_hold2", 6'b000110, 1'b0, REG_MASK, 32'h0, 1'b0);
        checkValue("t3_hw", 32'(hw_seen), 32'h02);
        checkValue("t3_vec", 32'(rd[3][2:0]), 32'h1);
        applyStimulus("t3_drop", 6'b000100, 1'b0, REG_MASK, 32'h0, 1'b0);
        checkValue("t3_hw_lag", 32'(hw_seen), 32'h02);
        applyStimulus("t3_drop2", 6'b000100, 1'b0, REG_MASK, 32'h0, 1'b0);
        checkValue("t3_hw_next", 32'(hw_seen), 32'h04);

        // Preemption of an in-service line
        applyStimulus("t4_mode", 6'h00, 1'b1, REG_MODE, 32'h3F, 1'b0);
        applyStimulus("t4_edge2", 6'b000100, 1'b0, REG_MASK, 32'h0, 1'b0);
        applyStimulus("t4_ack2", 6'h00, 1'b1, REG_CTRL, 32'h2, 1'b0);
        checkValue("t4_isr", 32'(rd[3][11:6]), 32'h04);
        applyStimulus("t4_edge0", 6'b000001, 1'b0, REG_MASK, 32'h0, 1'b0);
        applyStimulus("t4_wait", 6'h00, 1'b0, REG_MASK, 32'h0, 1'b0);
`ifdef PR_IRQ_NESTING_EN
        checkValue("t4_preempt", 32'(hw_seen), 32'h01);
`else
        checkValue("t4_blocked", 32'(hw_seen), 32'h00);
`endif
        applyStimulus("t4_eoi", 6'h00, 1'b1, REG_CTRL, 32'h8, 1'b0);
        applyStimulus("t4_post", 6'h00, 1'b0, REG_MASK, 32'h0, 1'b0);
        checkValue("t4_hw_eoi", 32'(hw_seen), 32'h01);
        applyStimulus("t4_ack0", 6'h00, 1'b1, REG_CTRL, 32'h0, 1'b0);
        applyStimulus("t4_eoi0", 6'h00, 1'b1, REG_CTRL, 32'h8, 1'b0);

        // Set beats W1C; masked ACK is ignored
        applyStimulus("t5_w1c", 6'b001000, 1'b1, REG_PEND, 32'h08, 1'b0);
        checkValue("t5_pend3", 32'(rd[2][3]), 32'h1);
        applyStimulus("t5_mask0", 6'h00, 1'b1, REG_MASK, 32'h0, 1'b0);
        applyStimulus("t5_ack3", 6'h00, 1'b1, REG_CTRL, 32'h3, 1'b0);
        checkValue("t5_isr", 32'(rd[3][11:6]), 32'h0);

        // Reset while a line is in service
        applyStimulus("t6_mask", 6'h00, 1'b1, REG_MASK, 32'h3F, 1'b0);
        applyStimulus("t6_clr", 6'h00, 1'b1, REG_PEND, 32'h3F, 1'b0);
        applyStimulus("t6_edge1", 6'b000010, 1'b0, REG_MASK, 32'h0, 1'b0);
        applyStimulus("t6_ack1", 6'h00, 1'b1, REG_CTRL, 32'h1, 1'b0);
        checkValue("t6_isr", 32'(rd[3][11:6]), 32'h02);
        applyStimulus("t6_reset", 6'h00, 1'b0, REG_MASK, 32'h0, 1'b1);
        checkValue("t6_hw", 32'(hw_seen), 32'h0);
        checkValue("t6_pend", rd[2], 32'h0);
        checkValue("t6_isr0", 32'(rd[3][11:6]), 32'h0);
        checkValue("t6_mask0", rd[0], 32'h0);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            r_irq = 6'($urandom);
            r_we  = ($urandom_range(0, 9) < 4);
            r_sel = 2'($urandom);
            r_din = $urandom;
            if (r_sel == REG_MASK && $urandom_range(0, 1) == 1) r_din = 32'h3F;
            r_rst = ($urandom_range(0, 99) == 0);
            applyStimulus($sformatf("rnd%0d", n), r_irq, r_we, r_sel, r_din, r_rst);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
